vga_cell_renderer: RTL and testbench
====================================

Name: vga_cell_renderer

Overview:
- Pixel back-end directly downstream of the VGA timing generator.
- Consumes the generator's active flag, pixel coordinates and h/v sync, and maps each pixel to a Game-of-Life cell.
- Fetches the cell state from the synchronous cell RAM and drives 4-bit-per-channel RGB plus sync outputs, delayed by the same number of cycles.
- Emits a frame-end pulse so the life engine knows when it may swap or update the cell buffer.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- CELL_SHIFT, 4, log2 of cell edge in pixels (16x16 px cells)
- GRID_W, 40, cells per row
- GRID_H, 30, cells per column
- COLOR_ALIVE, 12'hFFF, RGB444 for a live cell
- COLOR_DEAD, 12'h000, RGB444 for a dead cell
- COLOR_BORDER, 12'h222, RGB444 for pixels outside the grid
- COLOR_CURSOR, 12'hF00, RGB444 for the cursor outline

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- i_draw_active  in  1  pixel is in the visible area
- i_x  in  $clog2(H_ACTIVE)  active x; 0 when inactive
- i_y  in  $clog2(V_ACTIVE)  active y; 0 when inactive
- i_h_sync  in  1  hsync from timing generator, active low
- i_v_sync  in  1  vsync from timing generator, active low
- o_rd_en  out  1  cell RAM read enable
- o_rd_addr  out  $clog2(GRID_W*GRID_H)  cell index = row*GRID_W + col
- i_rd_data  in  1  cell alive; valid one cycle after o_rd_en/o_rd_addr are sampled by the RAM
- i_cursor_en  in  1  draw cursor outline
- i_cursor_col  in  $clog2(GRID_W)  cursor cell column
- i_cursor_row  in  $clog2(GRID_H)  cursor cell row
- o_r, o_g, o_b  out  4 each  pixel colour
- o_h_sync, o_v_sync  out  1 each  delayed syncs, active low
- o_frame_end  out  1  one-cycle pulse with last visible pixel

Behaviour:
- Pipeline has 3 register stages; every output lags its input by exactly 3 clk edges.
- S1, the edge after the inputs are sampled:
  - col = i_x >> CELL_SHIFT, row = i_y >> CELL_SHIFT
  - in_grid = i_draw_active & col < GRID_W & row < GRID_H
  - o_rd_en <= in_grid
  - o_rd_addr <= in_grid ? row*GRID_W+col : 0
  - Multiply is done at full index width; no truncation before the add.
  - Also register the active flag, in_grid, cursor-edge flag, sub-cell offsets and syncs.
- S2: the RAM returns i_rd_data. Stage-2 registers carry the side-band only; no use of i_rd_data yet.
- S3, output register, priority highest first:
  - !active -> RGB 0
  - !in_grid -> COLOR_BORDER
  - cursor edge -> COLOR_CURSOR
  - i_rd_data -> COLOR_ALIVE
  - else -> COLOR_DEAD
- i_rd_data is sampled on the edge that loads S3.
- Cursor edge:
  - i_cursor_en, and the cell is (i_cursor_col, i_cursor_row).
  - The pixel offset within the cell is 0 or 2^CELL_SHIFT-1 in x or in y.
  - Cursor inputs are sampled at S1; a change mid-frame takes effect on the next pixel.
- o_frame_end = 1 in the same cycle S3 outputs the pixel with x=H_ACTIVE-1, y=V_ACTIVE-1, active=1; otherwise 0.
- Reset (asynchronous, any time, including mid-line):
  - All pipeline valid/active bits are cleared.
  - o_rd_en=0, o_rd_addr=0, RGB=0, o_frame_end=0.
  - o_h_sync=1 and o_v_sync=1 (inactive).
  - After rst_n deasserts, the first 3 output cycles are blank and inactive regardless of the inputs.
- No backpressure; one pixel per clk, always.

Optional Feature:
- Macro: VGA_CELL_GRID_LINES_EN.
- Defined:
  - Pixels inside the grid with x-offset 0 or y-offset 0 within their cell show COLOR_BORDER.
  - Priority sits below the cursor and above alive/dead.
  - Result: a 1-px grid lattice.
- Undefined: no lattice; the logic is absent.
- Latency is unchanged in both cases.

Decomposition:
- Package vga_pkg holds:
  - H_ACTIVE, V_ACTIVE defaults
  - typedef rgb444_t (struct of three logic [3:0])
  - colour constants
  - the PIPE_LAT=3 constant, shared with the bench and top-level
- One natural sub-module: vga_delay_line (parameterised width and depth, async active-low reset, reset value parameter), used for the sync/side-band pipelining.

Test Plan:
- Reset mid-line (rst_n low 5 cycles while x=300) -> RGB=0, syncs=1, rd_en=0 immediately; first 3 cycles after release blank.
- Pixel (x=17, y=33) active -> o_rd_addr=2*40+1=81, rd_en=1 one edge later; RAM returns 1 -> RGB=FFF exactly 3 edges after input.
- Sync alignment: input hsync low for 96 cycles starting at x=656 -> o_h_sync low for 96 cycles starting 3 edges later; same for vsync.
- Cursor en at (col=2, row=1): pixel (32,16) -> F00; pixel (40,24) with cell alive -> FFF; pixel (47,20) -> F00.
- Last pixel (639,479) -> o_frame_end one cycle, coincident with its RGB; no pulse at (639,478).
- GRID_W=30 (grid 480 px wide): pixel x=500 active -> rd_en=0, RGB=222; with VGA_CELL_GRID_LINES_EN, pixel (48,50) alive -> 222.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_pkg
// Brief   : Shared types and constants for the VGA cell renderer: default
//           screen geometry, RGB444 pixel type, palette and pipeline latency.
// Rev     : 1.0  initial release
// ============================================================================
package vga_pkg;

  // Default visible geometry (640x480)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  // Input-to-output latency of the renderer, in clk edges
  localparam int PIPE_LAT = 3;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam rgb444_t DEF_COLOR_ALIVE  = 12'hFFF;
  localparam rgb444_t DEF_COLOR_DEAD   = 12'h000;
  localparam rgb444_t DEF_COLOR_BORDER = 12'h222;
  localparam rgb444_t DEF_COLOR_CURSOR = 12'hF00;
  localparam rgb444_t RGB_BLANK        = 12'h000;

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// Module  : vga_delay_line
// Brief   : Fixed-depth shift register used to carry sync and side-band bits
//           alongside the pixel pipeline. Async active-low reset loads every
//           stage with RESET_VAL.
// Rev     : 1.0  initial release
// ============================================================================
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift the word one stage per clock; reset parks every stage at RESET_VAL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_cell_renderer.sv
`default_nettype none
// ============================================================================
// Module  : vga_cell_renderer
// Brief   : Pixel back-end for the Game-of-Life display. Maps each visible
//           pixel to a grid cell, reads the cell from synchronous RAM and
//           drives RGB444 plus syncs, all delayed by PIPE_LAT clocks.
//           Optional macro VGA_CELL_GRID_LINES_EN draws a 1-px grid lattice.
// Rev     : 1.0  initial release
// ============================================================================
module vga_cell_renderer
  import vga_pkg::*;
#(
  parameter int      H_ACTIVE     = DEF_H_ACTIVE,
  parameter int      V_ACTIVE     = DEF_V_ACTIVE,
  parameter int      CELL_SHIFT   = 4,
  parameter int      GRID_W       = 40,
  parameter int      GRID_H       = 30,
  parameter rgb444_t COLOR_ALIVE  = DEF_COLOR_ALIVE,
  parameter rgb444_t COLOR_DEAD   = DEF_COLOR_DEAD,
  parameter rgb444_t COLOR_BORDER = DEF_COLOR_BORDER,
  parameter rgb444_t COLOR_CURSOR = DEF_COLOR_CURSOR
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_draw_active,
  input  logic [$clog2(H_ACTIVE)-1:0]         i_x,
  input  logic [$clog2(V_ACTIVE)-1:0]         i_y,
  input  logic                                i_h_sync,
  input  logic                                i_v_sync,
  output logic                                o_rd_en,
  output logic [$clog2(GRID_W*GRID_H)-1:0]    o_rd_addr,
  input  logic                                i_rd_data,
  input  logic                                i_cursor_en,
  input  logic [$clog2(GRID_W)-1:0]           i_cursor_col,
  input  logic [$clog2(GRID_H)-1:0]           i_cursor_row,
  output logic [3:0]                          o_r,
  output logic [3:0]                          o_g,
  output logic [3:0]                          o_b,
  output logic                                o_h_sync,
  output logic                                o_v_sync,
  output logic                                o_frame_end
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam int AW = $clog2(GRID_W*GRID_H);

  // Side-band word layout: {last, cursor_edge, in_grid, active}
  localparam int c_SB_W = 4;
  localparam logic [CELL_SHIFT-1:0] c_OFF_MAX = '1;

  // ---------------------------------------------------------------- stage 0
  logic [XW-1:0]         w_col;
  logic [YW-1:0]         w_row;
  logic [CELL_SHIFT-1:0] w_x_off;
  logic [CELL_SHIFT-1:0] w_y_off;
  logic                  w_in_grid;
  logic                  w_cur_cell;
  logic                  w_cur_edge;
  logic                  w_last;
  logic [AW-1:0]         w_idx;

  assign w_col   = i_x >> CELL_SHIFT;
  assign w_row   = i_y >> CELL_SHIFT;
  assign w_x_off = i_x[CELL_SHIFT-1:0];
  assign w_y_off = i_y[CELL_SHIFT-1:0];

  assign w_in_grid = i_draw_active
                   && (32'(w_col) < 32'(GRID_W))
                   && (32'(w_row) < 32'(GRID_H));

  // Full 32-bit multiply-add; only the final index is narrowed
  assign w_idx = AW'(32'(w_row) * 32'(GRID_W) + 32'(w_col));

  assign w_cur_cell = i_cursor_en
                    && (32'(w_col) == 32'(i_cursor_col))
                    && (32'(w_row) == 32'(i_cursor_row));

  assign w_cur_edge = w_cur_cell
                    && ((w_x_off == '0) || (w_x_off == c_OFF_MAX)
                     || (w_y_off == '0) || (w_y_off == c_OFF_MAX));

  assign w_last = i_draw_active
                && (32'(i_x) == 32'(H_ACTIVE - 1))
                && (32'(i_y) == 32'(V_ACTIVE - 1));

  // ---------------------------------------------------------------- stage 1
  logic          r_rd_en;
  logic [AW-1:0] r_rd_addr;

  // Issue the cell RAM read for in-grid pixels; address parks at 0 otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_rd_en   <= w_in_grid;
      r_rd_addr <= w_in_grid ? w_idx : '0;
    end
  end

  assign o_rd_en   = r_rd_en;
  assign o_rd_addr = r_rd_addr;

  // ------------------------------------------------ side-band through S1/S2
  logic [c_SB_W-1:0] w_sb_s2;
  logic              w_s2_active;
  logic              w_s2_in_grid;
  logic              w_s2_cur_edge;
  logic              w_s2_last;

  vga_delay_line #(
    .WIDTH     (c_SB_W),
    .DEPTH     (PIPE_LAT - 1),
    .RESET_VAL ('0)
  ) u_sb_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   ({w_last, w_cur_edge, w_in_grid, i_draw_active}),
    .o_q   (w_sb_s2)
  );

  assign {w_s2_last, w_s2_cur_edge, w_s2_in_grid, w_s2_active} = w_sb_s2;

`ifdef VGA_CELL_GRID_LINES_EN
  logic w_grid_line;
  logic w_s2_grid_line;

  assign w_grid_line = (w_x_off == '0) || (w_y_off == '0);

  vga_delay_line #(
    .WIDTH     (1),
    .DEPTH     (PIPE_LAT - 1),
    .RESET_VAL (1'b0)
  ) u_line_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_grid_line),
    .o_q   (w_s2_grid_line)
  );
`endif

  // Syncs ride the full pipeline depth and idle high (inactive) in reset
  vga_delay_line #(
    .WIDTH     (2),
    .DEPTH     (PIPE_LAT),
    .RESET_VAL (2'b11)
  ) u_sync_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   ({i_h_sync, i_v_sync}),
    .o_q   ({o_h_sync, o_v_sync})
  );

  // ---------------------------------------------------------------- stage 3
  rgb444_t w_pix_next;
  rgb444_t r_pix;
  logic    r_frame_end;

  // Colour selection in priority order; RAM data arrives on this edge
  always_comb begin
    w_pix_next = COLOR_DEAD;
    if (!w_s2_active) begin
      w_pix_next = RGB_BLANK;
    end else if (!w_s2_in_grid) begin
      w_pix_next = COLOR_BORDER;
    end else if (w_s2_cur_edge) begin
      w_pix_next = COLOR_CURSOR;
`ifdef VGA_CELL_GRID_LINES_EN
    end else if (w_s2_grid_line) begin
      w_pix_next = COLOR_BORDER;
`endif
    end else if (i_rd_data) begin
      w_pix_next = COLOR_ALIVE;
    end else begin
      w_pix_next = COLOR_DEAD;
    end
  end

  // Output register for the pixel colour and the frame-end strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix       <= RGB_BLANK;
      r_frame_end <= 1'b0;
    end else begin
      r_pix       <= w_pix_next;
      r_frame_end <= w_s2_last;
    end
  end

  assign o_r         = r_pix.r;
  assign o_g         = r_pix.g;
  assign o_b         = r_pix.b;
  assign o_frame_end = r_frame_end;

endmodule
`default_nettype wire

// File: tb/tb_vga_cell_renderer.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_cell_renderer
// Brief   : Scoreboard bench. Two renderers (40-wide and 30-wide grid) share
//           one stimulus stream; expected pixels/reads are queued at drive
//           time and popped by a monitor on the falling clock edge.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vga_cell_renderer;
  import vga_pkg::*;

  localparam int GW_A = 40;
  localparam int GW_B = 30;
  localparam int GH   = 30;

`ifdef VGA_CELL_GRID_LINES_EN
  localparam logic [11:0] OFF0_ALIVE = 12'h222;
  localparam logic [11:0] OFF0_DEAD  = 12'h222;
`else
  localparam logic [11:0] OFF0_ALIVE = 12'hFFF;
  localparam logic [11:0] OFF0_DEAD  = 12'h000;
`endif

  typedef struct {
    int          due;
    logic [11:0] a;
    logic [11:0] b;
    logic        hs;
    logic        vs;
    logic        fe;
  } out_t;

  typedef struct {
    int          due;
    logic        en_a;
    logic [10:0] ad_a;
    logic        en_b;
    logic [9:0]  ad_b;
  } rd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic draw_active = 1'b0;
  logic [9:0] x = '0;
  logic [8:0] y = '0;
  logic hs = 1'b1;
  logic vs = 1'b1;
  logic cur_en = 1'b0;
  int   cur_col = 0;
  int   cur_row = 0;
  logic [5:0] cur_col_a;
  logic [4:0] cur_col_b;
  logic [4:0] cur_row_v;

  logic        rd_en_a, rd_en_b, ram_a, ram_b;
  logic [10:0] rd_addr_a;
  logic [9:0]  rd_addr_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        hs_a, vs_a, fe_a, hs_b, vs_b, fe_b;

  logic cells_a [GW_A*GH];
  logic cells_b [GW_B*GH];

  out_t sb_q[$];
  rd_t  rd_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  logic in_reset = 1'b0;

  assign cur_col_a = 6'(cur_col);
  assign cur_col_b = 5'(cur_col);
  assign cur_row_v = 5'(cur_row);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_cell_renderer #(.GRID_W(GW_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_draw_active(draw_active), .i_x(x), .i_y(y),
    .i_h_sync(hs), .i_v_sync(vs), .o_rd_en(rd_en_a), .o_rd_addr(rd_addr_a),
    .i_rd_data(ram_a), .i_cursor_en(cur_en), .i_cursor_col(cur_col_a),
    .i_cursor_row(cur_row_v), .o_r(r_a), .o_g(g_a), .o_b(b_a),
    .o_h_sync(hs_a), .o_v_sync(vs_a), .o_frame_end(fe_a)
  );

  vga_cell_renderer #(.GRID_W(GW_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_draw_active(draw_active), .i_x(x), .i_y(y),
    .i_h_sync(hs), .i_v_sync(vs), .o_rd_en(rd_en_b), .o_rd_addr(rd_addr_b),
    .i_rd_data(ram_b), .i_cursor_en(cur_en), .i_cursor_col(cur_col_b),
    .i_cursor_row(cur_row_v), .o_r(r_b), .o_g(g_b), .o_b(b_b),
    .o_h_sync(hs_b), .o_v_sync(vs_b), .o_frame_end(fe_b)
  );

  // Synchronous single-cycle-latency cell RAMs
  always @(posedge clk) begin
    if (rd_en_a) ram_a <= cells_a[rd_addr_a];
    if (rd_en_b) ram_b <= cells_b[rd_addr_b];
  end

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [11:0] model_rgb(input int gw, input logic act, input int px, input int py);
    int col, row, ox, oy;
    logic alive;
    col = px >> 4; row = py >> 4; ox = px & 15; oy = py & 15;
    if (!act) return 12'h000;
    if (col >= gw || row >= GH) return 12'h222;
    if (cur_en && col == cur_col && row == cur_row && (ox == 0 || ox == 15 || oy == 0 || oy == 15))
      return 12'hF00;
`ifdef VGA_CELL_GRID_LINES_EN
    if (ox == 0 || oy == 0) return 12'h222;
`endif
    alive = (gw == GW_A) ? cells_a[row*gw+col] : cells_b[row*gw+col];
    return alive ? 12'hFFF : 12'h000;
  endfunction

  task automatic set_alive(input int col, input int row);
    cells_a[row*GW_A+col] = 1'b1;
    if (col < GW_B) cells_b[row*GW_B+col] = 1'b1;
  endtask

  // Drive one pixel, queue its expectations, advance to next posedge+1
  task automatic step(input logic act, input int px, input int py, input logic h, input logic v,
                      input logic hand, input logic [11:0] ha, input logic [11:0] hb);
    out_t o;
    rd_t  r;
    int   col, row;
    draw_active = act;
    x  = act ? 10'(px) : '0;
    y  = act ? 9'(py)  : '0;
    hs = h;
    vs = v;
    col = px >> 4; row = py >> 4;
    o.due = cyc + PIPE_LAT;
    r.due = cyc + 1;
    if (in_reset) begin
      o.a = '0; o.b = '0; o.hs = 1'b1; o.vs = 1'b1; o.fe = 1'b0;
      r.en_a = 1'b0; r.ad_a = '0; r.en_b = 1'b0; r.ad_b = '0;
    end else begin
      o.a  = hand ? ha : model_rgb(GW_A, act, px, py);
      o.b  = hand ? hb : model_rgb(GW_B, act, px, py);
      o.hs = h;
      o.vs = v;
      o.fe = act && px == 639 && py == 479;
      r.en_a = act && col < GW_A && row < GH;
      r.ad_a = r.en_a ? 11'(row*GW_A+col) : '0;
      r.en_b = act && col < GW_B && row < GH;
      r.ad_b = r.en_b ? 10'(row*GW_B+col) : '0;
    end
    sb_q.push_back(o);
    rd_q.push_back(r);
    @(posedge clk); #1;
  endtask

  task automatic pix(input int px, input int py, input logic [11:0] ha, input logic [11:0] hb);
    step(1'b1, px, py, 1'b1, 1'b1, 1'b1, ha, hb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, '0, '0);
  endtask

  task automatic run_line(input int py, input int hc0, input int hc1, input logic v);
    for (int hc = hc0; hc <= hc1; hc++)
      step(hc < 640 && py < 480, hc, py, !(hc >= 656 && hc < 752), v, 1'b0, '0, '0);
  endtask

  task automatic reset_now_checks();
    chk("rst_rgb_a",  {r_a, g_a, b_a}, 12'h000);
    chk("rst_rgb_b",  {r_b, g_b, b_b}, 12'h000);
    chk("rst_syncs",  {10'd0, hs_a, vs_a}, 12'h003);
    chk("rst_rd_en",  {10'd0, rd_en_a, rd_en_b}, 12'h000);
    chk("rst_rd_adr", {1'b0, rd_addr_a}, 12'h000);
    chk("rst_fe",     {10'd0, fe_a, fe_b}, 12'h000);
  endtask

  // Assert reset asynchronously mid-cycle, hold n cycles, then release
  task automatic reset_pulse(input int px, input int py, input int n);
    out_t o;
    rd_t  r;
    draw_active = 1'b1; x = 10'(px); y = 9'(py); hs = 1'b1; vs = 1'b1;
    rst_n = 1'b0;
    in_reset = 1'b1;
    sb_q.delete();
    rd_q.delete();
    o.a = '0; o.b = '0; o.hs = 1'b1; o.vs = 1'b1; o.fe = 1'b0;
    for (int d = 0; d < PIPE_LAT; d++) begin
      o.due = cyc + d;
      sb_q.push_back(o);
    end
    r.due = cyc; r.en_a = 1'b0; r.ad_a = '0; r.en_b = 1'b0; r.ad_b = '0;
    rd_q.push_back(r);
    #1;
    reset_now_checks();
    for (int i = 0; i < n; i++) step(1'b1, px, py, 1'b1, 1'b1, 1'b0, '0, '0);
    rst_n = 1'b1;
    in_reset = 1'b0;
  endtask

  // Monitor: compare whatever expectation is due this cycle
  always @(negedge clk) begin
    out_t o;
    rd_t  r;
    while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      o = sb_q.pop_front();
      chk("out_missed", 12'(o.due), 12'(cyc));
    end
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      o = sb_q.pop_front();
      chk("rgb_a", {r_a, g_a, b_a}, o.a);
      chk("rgb_b", {r_b, g_b, b_b}, o.b);
      chk("h_sync", {11'd0, hs_a}, {11'd0, o.hs});
      chk("v_sync", {11'd0, vs_a}, {11'd0, o.vs});
      chk("frame_end_a", {11'd0, fe_a}, {11'd0, o.fe});
      chk("sync_fe_b", {9'd0, hs_b, vs_b, fe_b}, {9'd0, o.hs, o.vs, o.fe});
    end
    while (rd_q.size() > 0 && rd_q[0].due < cyc) begin
      r = rd_q.pop_front();
      chk("rd_missed", 12'(r.due), 12'(cyc));
    end
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      r = rd_q.pop_front();
      chk("rd_a", {rd_en_a, rd_addr_a}, {r.en_a, r.ad_a});
      chk("rd_b", {1'b0, rd_en_b, rd_addr_b}, {1'b0, r.en_b, r.ad_b});
    end
  end

  initial begin
    for (int i = 0; i < GW_A*GH; i++) cells_a[i] = 1'b0;
    for (int i = 0; i < GW_B*GH; i++) cells_b[i] = 1'b0;
    ram_a = 1'b0;
    ram_b = 1'b0;

    // Power-on reset
    #1 rst_n = 1'b0;
    in_reset = 1'b1;
    #1 reset_now_checks();
    @(posedge clk); #1;
    idle(4);
    rst_n = 1'b1;
    in_reset = 1'b0;
    idle(2);

    set_alive(1, 2);
    set_alive(2, 1);
    set_alive(3, 3);
    set_alive(31, 3);

    // Basic cell lookup (A addr 81, B addr 61)
    pix(17, 33, 12'hFFF, 12'hFFF);
    pix(18, 33, 12'hFFF, 12'hFFF);
    pix(100, 100, 12'h000, 12'h000);
    step(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 12'h000, 12'h000);

    // Cursor outline on cell (2,1)
    cur_en = 1'b1; cur_col = 2; cur_row = 1;
    pix(32, 16, 12'hF00, 12'hF00);
    pix(40, 24, 12'hFFF, 12'hFFF);
    pix(47, 20, 12'hF00, 12'hF00);
    pix(40, 31, 12'hF00, 12'hF00);
    pix(48, 17, OFF0_DEAD, OFF0_DEAD);
    // Cursor moves mid-frame: effective on the very next pixel
    cur_col = 3;
    pix(48, 17, 12'hF00, 12'hF00);
    pix(32, 16, OFF0_ALIVE, OFF0_ALIVE);
    cur_en = 1'b0;
    pix(47, 20, 12'hFFF, 12'hFFF);

    // Grid-width boundary (B grid is 480 px wide)
    pix(48, 50, OFF0_ALIVE, OFF0_ALIVE);
    pix(500, 50, 12'hFFF, 12'h222);
    pix(479, 50, 12'h000, 12'h000);
    pix(480, 50, OFF0_DEAD, 12'h222);
    idle(2);

    // Sync alignment and frame-end across the last two visible lines
    run_line(478, 630, 799, 1'b1);
    run_line(479, 630, 799, 1'b1);
    run_line(480, 630, 799, 1'b0);
    idle(3);

    // Reset mid-line at x=300
    for (int hc = 290; hc < 300; hc++) step(1'b1, hc, 10, 1'b1, 1'b1, 1'b0, '0, '0);
    reset_pulse(300, 10, 5);
    for (int hc = 301; hc < 312; hc++) step(1'b1, hc, 10, 1'b1, 1'b1, 1'b0, '0, '0);

    // Drain with a bounded wait
    idle(PIPE_LAT + 2);
    chk("drain_out", 12'(sb_q.size() > 3 ? 1 : 0), 12'h000);
    repeat (4) @(negedge clk);
    chk("drain_out_empty", 12'(sb_q.size()), 12'h000);
    chk("drain_rd_empty", 12'(rd_q.size()), 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
